// File: rtl/radix2_butterfly_pipe_pkg.sv
// bfly_pkg: shared widths, complex type and output reduce helpers.
// Build macro BFLY_SAT_EN makes sat_or_wrap clamp instead of wrap.
package bfly_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;
  localparam int PW = DW_DEF + TW_DEF + 1;
  localparam int SW = DW_DEF + 3;
  localparam int ROUND_C = 2 ** (TW_DEF - 2);

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  function automatic logic signed [63:0] lim_hi(
    input int dw
  );
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] lim_lo(
    input int dw
  );
    return -(64'sd1 <<< (dw - 1));
  endfunction

  function automatic logic out_of_range(
    input logic signed [63:0] v,
    input int dw
  );
    return (v > lim_hi(dw)) || (v < lim_lo(dw));
  endfunction

  function automatic logic signed [63:0] sat_or_wrap(
    input logic signed [63:0] v,
    input int dw
  );
`ifdef BFLY_SAT_EN
    if (v > lim_hi(dw)) return lim_hi(dw);
    if (v < lim_lo(dw)) return lim_lo(dw);
    return v;
`else
    return (v <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/radix2_butterfly_pipe_if.sv
// Butterfly input/output bundle with valid/ready on both sides.
// master drives operands and out_ready; slave is the butterfly.
interface radix2_butterfly_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic in_valid;
  logic in_ready;
  logic signed [DW-1:0] a_re;
  logic signed [DW-1:0] a_im;
  logic signed [DW-1:0] b_re;
  logic signed [DW-1:0] b_im;
  logic signed [TW-1:0] w_re;
  logic signed [TW-1:0] w_im;
  logic inv;
  logic scale;
  logic out_valid;
  logic out_ready;
  logic signed [DW-1:0] y0_re;
  logic signed [DW-1:0] y0_im;
  logic signed [DW-1:0] y1_re;
  logic signed [DW-1:0] y1_im;
  logic ovf;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im,
    output w_re, w_im, inv, scale, out_ready,
    input  in_ready, out_valid,
    input  y0_re, y0_im, y1_re, y1_im, ovf
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im,
    input  w_re, w_im, inv, scale, out_ready,
    output in_ready, out_valid,
    output y0_re, y0_im, y1_re, y1_im, ovf
  );
endinterface

// File: rtl/radix2_butterfly_pipe_cmul.sv
// cmul_pipe: 2-stage complex multiply t = B*W (or B*conj(W)),
// partial products in S1, combine and round half-up in S2.
module cmul_pipe
  import bfly_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  input  logic inv,
  output logic signed [DW+1:0] t_re,
  output logic signed [DW+1:0] t_im
);

  localparam int P_W = DW + TW + 1;
  localparam logic signed [P_W-1:0] RND =
    P_W'(64'sd1 <<< (TW - 2));

  logic signed [TW:0] wr;
  logic signed [TW:0] wx;
  logic signed [TW:0] wi;
  logic signed [P_W-1:0] pr_rr;
  logic signed [P_W-1:0] pr_ii;
  logic signed [P_W-1:0] pr_ri;
  logic signed [P_W-1:0] pr_ir;
  logic signed [P_W-1:0] s_re;
  logic signed [P_W-1:0] s_im;
  logic signed [P_W-1:0] sh_re;
  logic signed [P_W-1:0] sh_im;

  // One extra bit so negating -2^(TW-1) stays exact.
  assign wr = $signed({w_re[TW-1], w_re});
  assign wx = $signed({w_im[TW-1], w_im});
  assign wi = inv ? -wx : wx;

  assign s_re = pr_rr - pr_ii + RND;
  assign s_im = pr_ri + pr_ir + RND;
  assign sh_re = s_re >>> (TW - 1);
  assign sh_im = s_im >>> (TW - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_rr <= '0;
      pr_ii <= '0;
      pr_ri <= '0;
      pr_ir <= '0;
      t_re  <= '0;
      t_im  <= '0;
    end else if (en) begin
      pr_rr <= b_re * wr;
      pr_ii <= b_im * wi;
      pr_ri <= b_re * wi;
      pr_ir <= b_im * wr;
      t_re  <= sh_re[DW+1:0];
      t_im  <= sh_im[DW+1:0];
    end
  end

endmodule

// File: rtl/radix2_butterfly_pipe.sv
// Radix-2 DIT butterfly, 3 stages, stall freezes the whole pipe.
// Build macro BFLY_SAT_EN: saturate outputs (default wraps).
module radix2_butterfly_pipe
  import bfly_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input logic clk,
  input logic rst_n,
  radix2_butterfly_pipe_if.slave bus
);

  localparam int S_W = DW + 3;
  localparam logic signed [S_W-1:0] ONE = 1;

  logic en;
  logic v1, v2, v3;
  logic sc1, sc2;
  logic signed [DW-1:0] a1_re, a1_im;
  logic signed [DW-1:0] a2_re, a2_im;
  logic signed [DW+1:0] t_re, t_im;
  logic signed [S_W-1:0] r [4];
  logic signed [63:0] q [4];
  logic nxt_ovf;
  logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;
  logic ovf_r;

  assign en = !v3 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.y0_re = y0_re;
  assign bus.y0_im = y0_im;
  assign bus.y1_re = y1_re;
  assign bus.y1_im = y1_im;
  assign bus.ovf   = ovf_r;

  cmul_pipe #(
    .DW(DW),
    .TW(TW)
  ) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .b_re (bus.b_re),
    .b_im (bus.b_im),
    .w_re (bus.w_re),
    .w_im (bus.w_im),
    .inv  (bus.inv),
    .t_re (t_re),
    .t_im (t_im)
  );

  function automatic logic signed [S_W-1:0] scl(
    input logic signed [S_W-1:0] v,
    input logic sc
  );
    return sc ? (v + ONE) >>> 1 : v;
  endfunction

  always_comb begin
    r[0] = scl(S_W'(a2_re) + S_W'(t_re), sc2);
    r[1] = scl(S_W'(a2_im) + S_W'(t_im), sc2);
    r[2] = scl(S_W'(a2_re) - S_W'(t_re), sc2);
    r[3] = scl(S_W'(a2_im) - S_W'(t_im), sc2);
    nxt_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q[k] = sat_or_wrap(64'(r[k]), DW);
      nxt_ovf = nxt_ovf | out_of_range(64'(r[k]), DW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      sc1   <= 1'b0;
      sc2   <= 1'b0;
      a1_re <= '0;
      a1_im <= '0;
      a2_re <= '0;
      a2_im <= '0;
      y0_re <= '0;
      y0_im <= '0;
      y1_re <= '0;
      y1_im <= '0;
      ovf_r <= 1'b0;
    end else if (en) begin
      v1    <= bus.in_valid;
      sc1   <= bus.scale;
      a1_re <= bus.a_re;
      a1_im <= bus.a_im;
      v2    <= v1;
      sc2   <= sc1;
      a2_re <= a1_re;
      a2_im <= a1_im;
      v3    <= v2;
      y0_re <= q[0][DW-1:0];
      y0_im <= q[1][DW-1:0];
      y1_re <= q[2][DW-1:0];
      y1_im <= q[3][DW-1:0];
      ovf_r <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Directed bench for radix2_butterfly_pipe (DW=TW=16).
// Expected Y0_re on overflow depends on BFLY_SAT_EN.
module tb_radix2_butterfly_pipe;
  import bfly_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  radix2_butterfly_pipe_if #(.DW(16), .TW(16)) bus ();

  radix2_butterfly_pipe #(
    .DW(16),
    .TW(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

`ifdef BFLY_SAT_EN
  localparam int OV_Y0 = 32767;
  localparam int MX_Y0 = 32767;
  localparam int MS_Y1 = -32768;
`else
  localparam int OV_Y0 = -1;
  localparam int MX_Y0 = -32768;
  localparam int MS_Y1 = 16384;
`endif

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ar, ai, br, bi, wr, wi, iv, sc);
    bus.in_valid = 1'b1;
    bus.a_re = 16'(ar);
    bus.a_im = 16'(ai);
    bus.b_re = 16'(br);
    bus.b_im = 16'(bi);
    bus.w_re = 16'(wr);
    bus.w_im = 16'(wi);
    bus.inv = iv[0];
    bus.scale = sc[0];
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.a_re = '0;
    bus.a_im = '0;
    bus.b_re = '0;
    bus.b_im = '0;
    bus.w_re = '0;
    bus.w_im = '0;
    bus.inv = 1'b0;
    bus.scale = 1'b0;
  endtask

  task automatic run1(input string tag, input int ar, ai, br, bi,
                      input int wr, wi, iv, sc,
                      input int e0r, e0i, e1r, e1i, eo);
    @(negedge clk);
    drive(ar, ai, br, bi, wr, wi, iv, sc);
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".early"}, 32'(bus.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.out_valid), 1);
    chk({tag, ".y0_re"}, 32'(bus.y0_re), e0r);
    chk({tag, ".y0_im"}, 32'(bus.y0_im), e0i);
    chk({tag, ".y1_re"}, 32'(bus.y1_re), e1r);
    chk({tag, ".y1_im"}, 32'(bus.y1_im), e1i);
    chk({tag, ".ovf"}, 32'(bus.ovf), eo);
  endtask

  initial begin
    int got;
    int sent;
    int stall;
    int frz;
    bit seen;
    bit acc;

    idle();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.in_ready", 32'(bus.in_ready), 1);
    chk("rst.y0_re", 32'(bus.y0_re), 0);
    chk("rst.y1_im", 32'(bus.y1_im), 0);
    chk("rst.ovf", 32'(bus.ovf), 0);

    run1("neg1", 1000, 200, 300, -50, -32768, 0, 0, 0,
         700, 250, 1300, 150, 0);
    run1("negj", 1000, 200, 300, -50, 0, -32768, 0, 0,
         950, -100, 1050, 500, 0);
    run1("negj_inv", 1000, 200, 300, -50, 0, -32768, 1, 0,
         1050, 500, 950, -100, 0);
    run1("scale", 1000, 200, 300, -50, -32768, 0, 0, 1,
         350, 125, 650, 75, 0);
    run1("round", 0, 0, 3, -3, 16384, 0, 0, 0,
         2, -1, -2, 1, 0);
    run1("ovf", 32767, 0, -32768, 0, -32768, 0, 0, 0,
         OV_Y0, 0, -1, 0, 1);
    run1("maxmag", -32768, -32768, -32768, -32768,
         -32768, -32768, 1, 0,
         MX_Y0, -32768, -32768, -32768, 1);
    run1("maxmag_sc", -32768, -32768, -32768, -32768,
         -32768, -32768, 1, 1,
         16384, -16384, MS_Y1, -16384, 1);

    // Six back-to-back, downstream stalls 5 cycles at first result.
    got = 0;
    sent = 0;
    stall = 0;
    frz = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        stall = 5;
        frz = 32'(bus.y0_re);
      end
      bus.out_ready = (stall == 0);
      if (sent < 6) drive(sent * 100, sent, 10, 0, -32768, 0, 0, 0);
      else idle();
      #1;
      if (stall > 0) begin
        chk("bp.in_ready", 32'(bus.in_ready), 0);
        chk("bp.frozen", 32'(bus.y0_re), frz);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp.y0_re", 32'(bus.y0_re), got * 100 - 10);
        chk("bp.y1_re", 32'(bus.y1_re), got * 100 + 10);
        chk("bp.y0_im", 32'(bus.y0_im), got);
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (stall > 0) stall--;
      @(posedge clk);
      if (acc) sent++;
    end
    #1 idle();
    bus.out_ready = 1'b1;
    chk("bp.got", got, 6);
    chk("bp.sent", sent, 6);
    @(negedge clk);
    chk("bp.nodup", 32'(bus.out_valid), 0);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(5, 5, 0, 0, -32768, 0, 0, 0);
      @(posedge clk);
    end
    #1 idle();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(bus.out_valid), 0);
    chk("mrst.y0_re", 32'(bus.y0_re), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst.stale", 32'(bus.out_valid), 0);
    end
    run1("post_rst", 123, -45, 300, -50, -32768, 0, 0, 0,
         -177, 5, 423, -95, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
